// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the controller: pc_src encodings,
// the canonical nop, and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned ST_W     = 2;
    localparam int unsigned CNT_W    = 64;

    // Next-PC source selects driven by the controller (2'b11 behaves as PLUS4)
    localparam logic [PC_SRC_W-1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_SRC_TARGET = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_SRC_ALU    = 2'b10;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // Fetch FSM states
    localparam logic [ST_W-1:0] ST_REQ   = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT  = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD  = 2'd2;
    localparam logic [ST_W-1:0] ST_FAULT = 2'd3;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection.
// Ports: pc, pc_src, imm_ext, alu_result in; next_pc and misaligned_target
// (next_pc[1] set) out. All arithmetic is modulo 2^32.
module next_pc_sel
    import fetch_unit_pkg::*;
(
    input  logic [XLEN-1:0]     pc,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [XLEN-1:0]     alu_result,
    output logic [XLEN-1:0]     next_pc,
    output logic                misaligned_target
);

    // Target mux; jalr clears the LSB of the ALU result
    always_comb begin
        next_pc = pc + XLEN'(32'd4);
        case (pc_src)
            PC_SRC_PLUS4:  next_pc = pc + XLEN'(32'd4);
            PC_SRC_TARGET: next_pc = pc + imm_ext;
            PC_SRC_ALU:    next_pc = alu_result & ~XLEN'(32'h1);
            default:       next_pc = pc + XLEN'(32'd4);
        endcase
    end

    assign misaligned_target = next_pc[1];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction
// memory over a valid/ready channel, holds the returned instruction for decode
// until retire, then steps the PC, traps misaligned targets, counts retires.
// Ports: clk, rst (sync, active-high); controller pc_src/imm_ext/alu_result/
// retire; imem request (valid/ready/addr) and response (valid/data); decode
// outputs instr/instr_valid/pc/pc_plus4; sticky misaligned; 64-bit instret.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_SRC_W-1:0] pc_src,
    input  logic [XLEN-1:0]     imm_ext,
    input  logic [XLEN-1:0]     alu_result,
    input  logic                retire,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    output logic [XLEN-1:0]     instr,
    output logic                instr_valid,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                misaligned,
    output logic [CNT_W-1:0]    instret
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] next_state;
    logic [XLEN-1:0] next_pc;
    logic            misaligned_target;

    next_pc_sel u_next_pc_sel (
        .pc                (pc),
        .pc_src            (pc_src),
        .imm_ext           (imm_ext),
        .alu_result        (alu_result),
        .next_pc           (next_pc),
        .misaligned_target (misaligned_target)
    );

    // Word-aligned request address; pc itself only moves on retire
    assign imem_req_addr = {pc[XLEN-1:2], 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_REQ;
        else     state <= next_state;
    end

    // Next-state logic; a request only counts once it is actually presented
    always_comb begin
        next_state = state;
        case (state)
            ST_REQ:   if (imem_req_valid && imem_req_ready) next_state = ST_WAIT;
            ST_WAIT:  if (imem_rsp_valid) next_state = ST_HOLD;
            ST_HOLD:  if (retire) next_state = misaligned_target ? ST_FAULT : ST_REQ;
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_REQ;
        endcase
    end

    // Registered outputs and datapath; flags are decoded from next_state so
    // they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            pc_plus4       <= RESET_PC + XLEN'(32'd4);
            instr          <= NOP;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b0;
            misaligned     <= 1'b0;
            instret        <= '0;
        end else begin
            imem_req_valid <= (next_state == ST_REQ);
            instr_valid    <= (next_state == ST_HOLD);
            if (state == ST_WAIT && imem_rsp_valid) begin
                instr <= imem_rsp_data;
            end
            if (state == ST_HOLD && retire) begin
                instret <= instret + CNT_W'(64'd1);
                if (misaligned_target) begin
                    misaligned <= 1'b1;
                end else begin
                    pc       <= next_pc;
                    pc_plus4 <= next_pc + XLEN'(32'd4);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected request addresses are queued
// as retires are driven and popped as the DUT issues requests.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_src;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        retire;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [63:0] instret;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_src         (pc_src),
        .imm_ext        (imm_ext),
        .alu_result     (alu_result),
        .retire         (retire),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misaligned     (misaligned),
        .instret        (instret)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] data_for(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [1:0] s,
                                               input logic [31:0] imm, input logic [31:0] alu);
        if (s == 2'b01)      return p + imm;
        else if (s == 2'b10) return {alu[31:1], 1'b0};
        else                 return p + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for a request, accept it; reports address and cycle seen
    task automatic take_req(output logic [31:0] addr, output bit ok, output int unsigned seen);
        ok   = 1'b0;
        addr = 32'hxxxx_xxxx;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid === 1'b1) begin
                ok   = 1'b1;
                addr = imem_req_addr;
                seen = cyc;
                break;
            end
            tick();
        end
        if (ok) begin
            imem_req_ready = 1'b1;
            tick();
            imem_req_ready = 1'b0;
        end
    endtask

    task automatic respond(input logic [31:0] d);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    // Retire with the given selects; afterwards drive junk to show they are
    // only sampled in the retire cycle
    task automatic do_retire(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
        pc_src     = s;
        imm_ext    = imm;
        alu_result = alu;
        retire     = 1'b1;
        tick();
        retire     = 1'b0;
        pc_src     = 2'b01;
        imm_ext    = 32'h0000_0BAD;
        alu_result = 32'h0000_0BAE;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc !== RST_PC ||
            pc_plus4 !== RST_PC + 32'd4 || instr !== NOP || misaligned !== 1'b0 || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_values: req_valid=%b instr_valid=%b pc=%h pc4=%h instr=%h mis=%b instret=%0d required 0 0 %h %h %h 0 0",
                     imem_req_valid, instr_valid, pc, pc_plus4, instr, misaligned, instret, RST_PC, RST_PC + 32'd4, NOP);
        end
        rst = 1'b0;
        n_tests++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_in_reset_cycle: req_valid=%b required 0", imem_req_valid);
        end
        tick();
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_request: req_valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RST_PC);
        end
    endtask

    task automatic test_stall();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req_valid=%b addr=%h instr_valid=%b required 1 %h 0",
                         i, imem_req_valid, imem_req_addr, instr_valid, RST_PC);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        n_tests++;
        if (instr !== NOP) begin
            n_fail++;
            $display("FAIL stall_spurious_rsp: instr=%h required %h", instr, NOP);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a, e;
        bit          ok;
        int unsigned seen, prev;
        prev = 0;
        exp_q.push_back(RST_PC);
        for (int k = 0; k < 3; k++) begin
            take_req(a, ok, seen);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || a !== e) begin
                n_fail++;
                $display("FAIL seq_req_addr[%0d]: ok=%0d addr=%h required %h", k, ok, a, e);
            end
            if (k > 0) begin
                n_tests++;
                if (seen - prev != 3) begin
                    n_fail++;
                    $display("FAIL seq_throughput[%0d]: %0d cycles/instr required 3", k, seen - prev);
                end
            end
            prev = seen;
            respond(data_for(e));
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== data_for(e) || pc !== e || pc_plus4 !== e + 32'd4) begin
                n_fail++;
                $display("FAIL seq_hold[%0d]: valid=%b instr=%h pc=%h pc4=%h required 1 %h %h %h",
                         k, instr_valid, instr, pc, pc_plus4, data_for(e), e, e + 32'd4);
            end
            do_retire(2'b00, 32'h0000_0040, 32'h0000_0888);
            exp_q.push_back(model_next(e, 2'b00, 32'h0000_0040, 32'h0000_0888));
        end
        n_tests++;
        if (instret !== 64'd3) begin
            n_fail++;
            $display("FAIL seq_instret: instret=%0d required 3", instret);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a, e, held_instr, held_pc;
        logic [63:0] ir;
        bit          ok;
        int unsigned seen;
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e) begin
            n_fail++;
            $display("FAIL br_req_addr0: ok=%0d addr=%h required %h", ok, a, e);
        end
        respond(data_for(e));
        held_instr = data_for(e);
        held_pc    = e;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== held_instr || pc !== held_pc || imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                         i, instr_valid, instr, pc, imem_req_valid, held_instr, held_pc);
            end
        end
        do_retire(2'b10, 32'h0000_0000, 32'h0000_0201);
        exp_q.push_back(model_next(e, 2'b10, 32'h0000_0000, 32'h0000_0201));
        // retire while in REQ must be ignored
        ir = instret;
        pc_src  = 2'b01;
        imm_ext = 32'h0000_0040;
        retire  = 1'b1;
        tick();
        tick();
        retire  = 1'b0;
        n_tests++;
        if (pc !== 32'h0000_0200 || imem_req_addr !== 32'h0000_0200 || instret !== ir) begin
            n_fail++;
            $display("FAIL retire_outside_hold: pc=%h addr=%h instret=%0d required 00000200 00000200 %0d",
                     pc, imem_req_addr, instret, ir);
        end
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e) begin
            n_fail++;
            $display("FAIL br_req_addr1: ok=%0d addr=%h required %h", ok, a, e);
        end
        respond(data_for(e));
        do_retire(2'b01, 32'hFFFF_FFF0, 32'h0000_0777);
        exp_q.push_back(model_next(e, 2'b01, 32'hFFFF_FFF0, 32'h0000_0777));
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e || a !== 32'h0000_01F0) begin
            n_fail++;
            $display("FAIL br_target: ok=%0d addr=%h required %h", ok, a, e);
        end
        respond(data_for(e));
    endtask

    task automatic test_jalr();
        logic [31:0] a, e;
        logic [63:0] ir;
        bit          ok;
        int unsigned seen;
        do_retire(2'b10, 32'h0000_0010, 32'h0000_0305);
        exp_q.push_back(model_next(32'h0000_01F0, 2'b10, 32'h0000_0010, 32'h0000_0305));
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e || a !== 32'h0000_0304) begin
            n_fail++;
            $display("FAIL jalr_target: ok=%0d addr=%h required %h", ok, a, e);
        end
        respond(data_for(e));
        ir = instret;
        do_retire(2'b10, 32'h0000_0000, 32'h0000_0306);
        n_tests++;
        if (misaligned !== 1'b1 || pc !== 32'h0000_0304 || instr_valid !== 1'b0 ||
            imem_req_valid !== 1'b0 || instret !== ir + 64'd1) begin
            n_fail++;
            $display("FAIL jalr_fault: mis=%b pc=%h valid=%b req=%b instret=%0d required 1 00000304 0 0 %0d",
                     misaligned, pc, instr_valid, imem_req_valid, instret, ir + 64'd1);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        retire         = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (imem_req_valid !== 1'b0 || misaligned !== 1'b1 || instr_valid !== 1'b0 || instret !== ir + 64'd1) begin
                n_fail++;
                $display("FAIL fault_terminal[%0d]: req=%b mis=%b valid=%b instret=%0d required 0 1 0 %0d",
                         i, imem_req_valid, misaligned, instr_valid, instret, ir + 64'd1);
            end
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        retire         = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] a, e;
        bit          ok;
        int unsigned seen;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_tests++;
        if (misaligned !== 1'b0 || pc !== RST_PC || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL fault_cleared: mis=%b pc=%h instret=%0d required 0 %h 0", misaligned, pc, instret, RST_PC);
        end
        exp_q.push_back(RST_PC);
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        respond(data_for(e));
        do_retire(2'b10, 32'h0, 32'hFFFF_FFFC);
        exp_q.push_back(model_next(e, 2'b10, 32'h0, 32'hFFFF_FFFC));
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e) begin
            n_fail++;
            $display("FAIL wrap_req_top: ok=%0d addr=%h required %h", ok, a, e);
        end
        respond(data_for(e));
        n_tests++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_pc_plus4: pc=%h pc4=%h required fffffffc 00000000", pc, pc_plus4);
        end
        // response strobe in HOLD must not disturb the held instruction
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_2222;
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++;
        if (instr !== data_for(e) || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_spurious_rsp: instr=%h valid=%b required %h 1", instr, instr_valid, data_for(e));
        end
        do_retire(2'b00, 32'h0, 32'h0);
        exp_q.push_back(model_next(e, 2'b00, 32'h0, 32'h0));
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h3333_4444;
        tick();
        imem_rsp_valid = 1'b0;
        take_req(a, ok, seen);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || a !== e || a !== 32'h0 || misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_req_zero: ok=%0d addr=%h mis=%b required %h 0", ok, a, misaligned, e);
        end
        respond(data_for(e));
        n_tests++;
        if (instr !== data_for(e)) begin
            n_fail++;
            $display("FAIL req_spurious_rsp: instr=%h required %h", instr, data_for(e));
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a;
        bit          ok;
        int unsigned seen;
        do_retire(2'b00, 32'h0, 32'h0);
        take_req(a, ok, seen);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (pc !== RST_PC || instr !== NOP || instr_valid !== 1'b0 || instret !== 64'd0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_wait: pc=%h instr=%h valid=%b instret=%0d req=%b required %h %h 0 0 0",
                     pc, instr, instr_valid, instret, imem_req_valid, RST_PC, NOP);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_6666;
        tick();
        tick();
        imem_rsp_valid = 1'b0;
        n_tests++;
        if (instr !== NOP || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL late_rsp_dropped: instr=%h valid=%b req=%b addr=%h required %h 0 1 %h",
                     instr, instr_valid, imem_req_valid, imem_req_addr, NOP, RST_PC);
        end
        take_req(a, ok, seen);
        respond(data_for(RST_PC));
        n_tests++;
        if (!ok || a !== RST_PC || instr !== data_for(RST_PC) || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL refetch_after_reset: ok=%0d addr=%h instr=%h valid=%b required %h %h 1",
                     ok, a, instr, instr_valid, RST_PC, data_for(RST_PC));
        end
    endtask

    initial begin
        rst            = 1'b1;
        pc_src         = 2'b00;
        imm_ext        = 32'h0;
        alu_result     = 32'h0;
        retire         = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        test_reset();
        test_stall();
        test_sequential();
        test_branch();
        test_jalr();
        test_wrap();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core, sitting directly upstream of the main controller/decoder. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and holds the returned instruction stable for decode until the core retires it. On retire it selects the next PC from the controller's `pc_src` (PC+4, PC+imm, or ALU result for `jalr`), traps misaligned targets, and counts retired instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset is synchronous and active-high
- `pc_src`  in  2  from controller: 00 PC+4, 01 PC+imm_ext, 10 alu_result (jalr), 11 treated as 00
- `imm_ext`  in  32  sign-extended immediate for branch/jal target
- `alu_result`  in  32  jalr target before LSB clear
- `retire`  in  1  core has finished the instruction currently presented
- `imem_req_valid`  out  1  read request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address (bits [1:0] always 00)
- `imem_rsp_valid`  in  1  read data valid, earliest one cycle after acceptance
- `imem_rsp_data`  in  32  instruction word
- `instr`  out  32  instruction to decode
- `instr_valid`  out  1  `instr`/`pc`/`pc_plus4` valid
- `pc`  out  32  address of `instr`
- `pc_plus4`  out  32  pc + 4, for link writeback
- `misaligned`  out  1  sticky: a target had bit 1 set
- `instret`  out  64  retired-instruction count

## Operation
- FSM states: REQ, WAIT, HOLD, FAULT.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready` -> WAIT.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`: capture `imem_rsp_data` into `instr` -> HOLD.
- HOLD: `instr_valid`=1. On `retire`: compute next PC, increment `instret`. If next PC[1]=1 -> FAULT with `misaligned`=1 and `pc` unchanged; else `pc`<=next PC -> REQ.
- FAULT: terminal until `rst`; `instr_valid`=0, no requests.
- Next PC: 00/11 -> pc+4; 01 -> pc+imm_ext; 10 -> alu_result & ~32'h1. All modulo 2^32 (wrap from 32'hFFFF_FFFC +4 -> 0, no flag).
- `retire` outside HOLD is ignored. `imem_rsp_valid` outside WAIT is ignored (no buffering).
- `pc_src`, `imm_ext`, `alu_result` are sampled only in the retire cycle.
- `instret` wraps at 2^64 silently.

## Timing
- Reset values: `pc`=RESET_PC, state REQ, `instr`=32'h0000_0013 (nop), `instr_valid`=0, `imem_req_valid`=0 during the reset cycle, `misaligned`=0, `instret`=0.
- First request asserted the cycle after `rst` deasserts.
- Best-case throughput: ready in REQ cycle, response next cycle -> `instr_valid` two cycles after request, retire same cycle -> new request next cycle: 3 cycles/instruction.
- `imem_req_addr` stable while `imem_req_valid`=1 and not accepted.
- `instr`, `pc`, `pc_plus4` stable throughout HOLD.
- `rst` in any state (including WAIT with an outstanding request) returns to reset values next cycle; instruction memory shares `rst` and drops outstanding reads.

## Structure
- Shared package: `pc_src` encodings (PC_SRC_PLUS4=2'b00, PC_SRC_TARGET=2'b01, PC_SRC_ALU=2'b10), NOP constant 32'h0000_0013, FSM state encoding; the controller includes the same `pc_src` constants.
- One combinational sub-module `next_pc_sel`: pc, pc_src, imm_ext, alu_result -> next_pc, misaligned_target.
- PC register, FSM, `instret` counter in `fetch_unit`.

## Test plan
- Reset, RESET_PC=32'h100, memory always ready, 1-cycle response -> requests at 0x100, 0x104, 0x108 with retire each HOLD; `instret`=3.
- `imem_req_ready` low 4 cycles -> `imem_req_addr` held at 0x100, `instr_valid` stays 0, no state advance.
- Branch: pc=0x200, pc_src=01, imm_ext=32'hFFFF_FFF0 on retire -> next request 0x1F0.
- jalr: pc_src=10, alu_result=32'h0000_0305 -> next request 0x304; alu_result=0x306 -> FAULT, `misaligned`=1, `pc` stays, no further requests until `rst`.
- pc=32'hFFFF_FFFC, pc_src=00 retire -> request 0x0, no fault; spurious `imem_rsp_valid` during REQ ignored.
- `rst` asserted in WAIT -> next cycle `pc`=RESET_PC, `instr`=nop, `instr_valid`=0, `instret`=0; late `imem_rsp_valid` in REQ dropped.
